// File: rtl/pixel_frame_writer.sv
// Packs a valid-only pixel stream into 32-bit words (4 bytes each) and writes them
// to a frame buffer through a small FIFO. Define PIXEL_FRAME_WRITER_SATURATE_EN to saturate instead of truncate.
module pixel_frame_writer #(
    parameter int IN_WIDTH   = 11,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [IN_WIDTH-1:0]   pixel_in,
    input  logic                  pixel_in_valid,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(NPIX - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_EMPTY = {(PTR_W + 1){1'b0}};

`ifdef PIXEL_FRAME_WRITER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Zero-extend first so narrow inputs need no special case.
    function automatic logic [7:0] reduce_byte(input logic [IN_WIDTH-1:0] p);
        logic [IN_WIDTH+7:0] ext;
        ext = {8'd0, p};
        if (SAT_EN && (|ext[IN_WIDTH+7:8])) begin
            reduce_byte = 8'hFF;
        end else begin
            reduce_byte = ext[7:0];
        end
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [1:0]            lane_q, lane_d;
    logic [23:0]           acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, done_q;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        fifo_cnt_q, fifo_cnt_d;

    logic [7:0]  byte_s;
    logic [31:0] push_word_s;
    logic        take_s, last_s, push_req_s, push_ok_s, pop_s, fifo_full_s, fifo_nonempty_s;

    // Pixel intake, packing and FIFO handshake decode.
    always_comb begin
        byte_s          = reduce_byte(pixel_in);
        push_word_s     = {8'd0, acc_q} | ({24'd0, byte_s} << {lane_q, 3'b000});
        take_s          = (state_q == S_RUN) && pixel_in_valid;
        last_s          = (pix_cnt_q == LAST_PIX);
        push_req_s      = take_s && ((lane_q == 2'd3) || last_s);
        fifo_nonempty_s = (fifo_cnt_q != FIFO_EMPTY);
        fifo_full_s     = (fifo_cnt_q == FIFO_FULL);
        pop_s           = fifo_nonempty_s && mem_wr_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok_s       = push_req_s && (!fifo_full_s || pop_s);
    end

    // Frame state machine next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_RUN;
                else             state_d = S_IDLE;
            end
            S_RUN: begin
                if (take_s && last_s) state_d = S_FLUSH;
                else                  state_d = S_RUN;
            end
            S_FLUSH: begin
                if (!fifo_nonempty_s) state_d = S_DONE;
                else                  state_d = S_FLUSH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel counter, lane, partial word, word address and overflow next-state.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        lane_d    = lane_q;
        acc_d     = acc_q;
        waddr_d   = waddr_q;
        ovf_d     = ovf_q;
        if ((state_q == S_IDLE) && frame_start) begin
            pix_cnt_d = {CNT_W{1'b0}};
            lane_d    = 2'd0;
            acc_d     = 24'd0;
            waddr_d   = {ADDR_WIDTH{1'b0}};
            ovf_d     = 1'b0;
        end else if (take_s) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            lane_d    = lane_q + 2'd1;
            if (push_req_s) begin
                acc_d   = 24'd0;
                waddr_d = waddr_q + ADDR_WIDTH'(1);
                ovf_d   = ovf_q | ~push_ok_s;
            end else begin
                acc_d   = push_word_s[23:0];
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else           wr_ptr_d = wr_ptr_q;
        if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else       rd_ptr_d = rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= {CNT_W{1'b0}};
            lane_q     <= 2'd0;
            acc_q      <= 24'd0;
            waddr_q    <= {ADDR_WIDTH{1'b0}};
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            fifo_cnt_q <= FIFO_EMPTY;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            waddr_q    <= waddr_d;
            ovf_q      <= ovf_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= {ADDR_WIDTH{1'b0}};
                fifo_data_q[i] <= 32'd0;
            end
        end else if (push_ok_s) begin
            fifo_addr_q[wr_ptr_q] <= waddr_q;
            fifo_data_q[wr_ptr_q] <= push_word_s;
        end else begin
            fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
        end
    end

    assign mem_wr_valid = fifo_nonempty_s;
    assign mem_wr_addr  = fifo_nonempty_s ? fifo_addr_q[rd_ptr_q] : {ADDR_WIDTH{1'b0}};
    assign mem_wr_data  = fifo_nonempty_s ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign overflow     = ovf_q;

endmodule
